// File: rtl/midi_pkg.sv
// Shared types and register-layout helpers for the MIDI command bridge.
package midi_pkg;

    localparam int MIDI_WORD_W = 22;

    // System messages bypass the RX channel filter.
    localparam logic [3:0] CMD_SYS = 4'hF;

    typedef struct packed {
        logic [3:0] cmd;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_word_t;

    // Register layout: {8'x, cmd, ch, 1'x, d1, 1'x, d2}; the x bits are ignored.
    function automatic midi_word_t reg_to_word(input logic [31:0] r);
        midi_word_t w;
        w.cmd = r[23:20];
        w.ch  = r[19:16];
        w.d1  = r[14:8];
        w.d2  = r[6:0];
        return w;
    endfunction

    // Readback layout with the spare bits forced to zero.
    function automatic logic [31:0] word_to_reg(input midi_word_t w);
        return {8'd0, w.cmd, w.ch, 1'b0, w.d1, 1'b0, w.d2};
    endfunction

    // Only status nibbles (MSB set) are legal MIDI commands.
    function automatic logic is_status(input logic [3:0] cmd);
        return cmd[3];
    endfunction

endpackage

// File: rtl/midi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit level counter.
// Push while full and pop while empty are ignored; full/empty come from
// the registered level, so same-cycle push/pop never changes the decision.
module midi_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    logic do_push;
    logic do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointers wrap naturally; level moves only on an unbalanced push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset flushes the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; never reset, stale entries are hidden by the level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Head is forced to zero while empty so stale data never leaks out.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/midi_cmd_bridge.sv
// Register-bus <-> MIDI command bridge: validates and buffers TX commands,
// filters and buffers RX commands by channel, keeps saturating statistics.
module midi_cmd_bridge
    import midi_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int TX_AFULL = TX_DEPTH - 2,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          cmd_wr,
    input  logic [31:0]                   cmd_wdata,
    output logic                          cmd_wbusy,
    input  logic                          cmd_rd,
    output logic [31:0]                   cmd_rdata,
    output logic                          cmd_rvalid,

    output logic [3:0]                    midi_tx_cmd,
    output logic [3:0]                    midi_tx_ch,
    output logic [6:0]                    midi_tx_data1,
    output logic [6:0]                    midi_tx_data2,
    output logic                          midi_tx_valid,
    input  logic                          midi_tx_rd,
    input  logic                          midi_tx_busy,

    input  logic [3:0]                    midi_rx_cmd,
    input  logic [3:0]                    midi_rx_ch,
    input  logic [6:0]                    midi_rx_data1,
    input  logic [6:0]                    midi_rx_data2,
    input  logic                          midi_rx_valid,
    output logic                          midi_rx_rd,

    input  logic [15:0]                   ch_mask,
    input  logic                          cnt_clr,

    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
    output logic [CNT_W-1:0]              tx_drop_cnt,
    output logic [CNT_W-1:0]              tx_err_cnt,
    output logic [CNT_W-1:0]              rx_filt_cnt
);

    localparam int TX_LVL_W = $clog2(TX_DEPTH + 1);
    localparam int RX_LVL_W = $clog2(RX_DEPTH + 1);

    localparam logic [TX_LVL_W-1:0] TX_AFULL_LVL = TX_LVL_W'(TX_AFULL);
    localparam logic [CNT_W-1:0]    CNT_MAX      = '1;

    // Reserved register bits are deliberately ignored.
    logic unused_wdata_bits;
    assign unused_wdata_bits = ^{cmd_wdata[31:24], cmd_wdata[15], cmd_wdata[7]};

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    midi_word_t              tx_in;
    midi_word_t              tx_head;
    logic                    tx_empty;
    logic                    tx_full;
    logic                    tx_push;
    logic                    wr_legal;
    logic                    tx_err_inc;
    logic                    tx_drop_inc;
    logic [TX_LVL_W-1:0]     tx_level_w;

    assign tx_in       = reg_to_word(cmd_wdata);
    assign wr_legal    = is_status(tx_in.cmd);

    // Legality is judged before capacity, so an illegal write into a full
    // FIFO counts as an error, not a drop.
    assign tx_err_inc  = cmd_wr & ~wr_legal;
    assign tx_drop_inc = cmd_wr & wr_legal & tx_full;
    assign tx_push     = cmd_wr & wr_legal & ~tx_full;

    midi_sync_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (MIDI_WORD_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (midi_tx_rd),
        .din   (tx_in),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .level (tx_level_w)
    );

    assign midi_tx_cmd   = tx_head.cmd;
    assign midi_tx_ch    = tx_head.ch;
    assign midi_tx_data1 = tx_head.d1;
    assign midi_tx_data2 = tx_head.d2;
    assign midi_tx_valid = ~tx_empty;
    assign tx_level      = tx_level_w;

    // Advisory only: writes are never gated on this.
    assign cmd_wbusy = (tx_level_w >= TX_AFULL_LVL) | midi_tx_busy;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    midi_word_t              rx_in;
    midi_word_t              rx_head;
    logic                    rx_empty;
    logic                    rx_full;
    logic                    rx_accept;
    logic                    rx_push;
    logic                    rx_filt_inc;
    logic [RX_LVL_W-1:0]     rx_level_w;

    assign rx_in.cmd = midi_rx_cmd;
    assign rx_in.ch  = midi_rx_ch;
    assign rx_in.d1  = midi_rx_data1;
    assign rx_in.d2  = midi_rx_data2;

    // Every consumed word is either stored or counted as filtered.
    assign midi_rx_rd  = midi_rx_valid & ~rx_full;
    assign rx_accept   = (rx_in.cmd == CMD_SYS) | ch_mask[rx_in.ch];
    assign rx_push     = midi_rx_rd & rx_accept;
    assign rx_filt_inc = midi_rx_rd & ~rx_accept;

    midi_sync_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (MIDI_WORD_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (cmd_rd),
        .din   (rx_in),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .level (rx_level_w)
    );

    assign cmd_rdata  = word_to_reg(rx_head);
    assign cmd_rvalid = ~rx_empty;
    assign rx_level   = rx_level_w;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tx_drop_cnt_q, tx_drop_cnt_d;
    logic [CNT_W-1:0] tx_err_cnt_q,  tx_err_cnt_d;
    logic [CNT_W-1:0] rx_filt_cnt_q, rx_filt_cnt_d;

    // Saturating increments; a clear overrides any same-cycle event.
    always_comb begin
        tx_drop_cnt_d = tx_drop_cnt_q;
        tx_err_cnt_d  = tx_err_cnt_q;
        rx_filt_cnt_d = rx_filt_cnt_q;
        if (cnt_clr) begin
            tx_drop_cnt_d = '0;
            tx_err_cnt_d  = '0;
            rx_filt_cnt_d = '0;
        end else begin
            if (tx_drop_inc && (tx_drop_cnt_q != CNT_MAX)) begin
                tx_drop_cnt_d = tx_drop_cnt_q + CNT_W'(1);
            end
            if (tx_err_inc && (tx_err_cnt_q != CNT_MAX)) begin
                tx_err_cnt_d = tx_err_cnt_q + CNT_W'(1);
            end
            if (rx_filt_inc && (rx_filt_cnt_q != CNT_MAX)) begin
                rx_filt_cnt_d = rx_filt_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_drop_cnt_q <= '0;
            tx_err_cnt_q  <= '0;
            rx_filt_cnt_q <= '0;
        end else begin
            tx_drop_cnt_q <= tx_drop_cnt_d;
            tx_err_cnt_q  <= tx_err_cnt_d;
            rx_filt_cnt_q <= rx_filt_cnt_d;
        end
    end

    assign tx_drop_cnt = tx_drop_cnt_q;
    assign tx_err_cnt  = tx_err_cnt_q;
    assign rx_filt_cnt = rx_filt_cnt_q;

endmodule

// File: tb/tb_midi_cmd_bridge.sv
// Bench for midi_cmd_bridge with small FIFOs and 2-bit counters so that
// full, almost-full and saturation corners are reached quickly.
module tb_midi_cmd_bridge;

    localparam int TX_D  = 4;
    localparam int RX_D  = 4;
    localparam int AFULL = 2;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_wr;
    logic [31:0] cmd_wdata;
    logic        cmd_wbusy;
    logic        cmd_rd;
    logic [31:0] cmd_rdata;
    logic        cmd_rvalid;
    logic [3:0]  midi_tx_cmd;
    logic [3:0]  midi_tx_ch;
    logic [6:0]  midi_tx_data1;
    logic [6:0]  midi_tx_data2;
    logic        midi_tx_valid;
    logic        midi_tx_rd;
    logic        midi_tx_busy;
    logic [3:0]  midi_rx_cmd;
    logic [3:0]  midi_rx_ch;
    logic [6:0]  midi_rx_data1;
    logic [6:0]  midi_rx_data2;
    logic        midi_rx_valid;
    logic        midi_rx_rd;
    logic [15:0] ch_mask;
    logic        cnt_clr;
    logic [2:0]  tx_level;
    logic [2:0]  rx_level;
    logic [1:0]  tx_drop_cnt;
    logic [1:0]  tx_err_cnt;
    logic [1:0]  rx_filt_cnt;

    midi_cmd_bridge #(
        .TX_DEPTH (TX_D),
        .RX_DEPTH (RX_D),
        .TX_AFULL (AFULL),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_wr        (cmd_wr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wbusy     (cmd_wbusy),
        .cmd_rd        (cmd_rd),
        .cmd_rdata     (cmd_rdata),
        .cmd_rvalid    (cmd_rvalid),
        .midi_tx_cmd   (midi_tx_cmd),
        .midi_tx_ch    (midi_tx_ch),
        .midi_tx_data1 (midi_tx_data1),
        .midi_tx_data2 (midi_tx_data2),
        .midi_tx_valid (midi_tx_valid),
        .midi_tx_rd    (midi_tx_rd),
        .midi_tx_busy  (midi_tx_busy),
        .midi_rx_cmd   (midi_rx_cmd),
        .midi_rx_ch    (midi_rx_ch),
        .midi_rx_data1 (midi_rx_data1),
        .midi_rx_data2 (midi_rx_data2),
        .midi_rx_valid (midi_rx_valid),
        .midi_rx_rd    (midi_rx_rd),
        .ch_mask       (ch_mask),
        .cnt_clr       (cnt_clr),
        .tx_level      (tx_level),
        .rx_level      (rx_level),
        .tx_drop_cnt   (tx_drop_cnt),
        .tx_err_cnt    (tx_err_cnt),
        .rx_filt_cnt   (rx_filt_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queues of readback-format words plus plain counters.
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    int m_drop = 0;
    int m_err  = 0;
    int m_filt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] norm(input logic [31:0] w);
        return {8'd0, w[23:16], 1'b0, w[14:8], 1'b0, w[6:0]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // Apply one clock edge's worth of the rules to the model.
    task automatic model_step(input logic rx_take);
        logic        tx_was_full;
        logic [31:0] rw;
        logic        drop, err, filt;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_drop = 0;
            m_err  = 0;
            m_filt = 0;
            return;
        end
        drop = 1'b0;
        err  = 1'b0;
        filt = 1'b0;
        tx_was_full = (m_tx.size() == TX_D);
        if (midi_tx_rd && m_tx.size() > 0) void'(m_tx.pop_front());
        if (cmd_wr) begin
            if (!cmd_wdata[23])   err = 1'b1;
            else if (tx_was_full) drop = 1'b1;
            else                  m_tx.push_back(norm(cmd_wdata));
        end
        if (cmd_rd && m_rx.size() > 0) void'(m_rx.pop_front());
        if (rx_take) begin
            rw = {8'd0, midi_rx_cmd, midi_rx_ch, 1'b0, midi_rx_data1, 1'b0, midi_rx_data2};
            if (midi_rx_cmd == 4'hF || ch_mask[midi_rx_ch]) m_rx.push_back(rw);
            else                                              filt = 1'b1;
        end
        if (cnt_clr) begin
            m_drop = 0;
            m_err  = 0;
            m_filt = 0;
        end else begin
            if (drop) m_drop = sat_inc(m_drop);
            if (err)  m_err  = sat_inc(m_err);
            if (filt) m_filt = sat_inc(m_filt);
        end
    endtask

    task automatic check_state();
        chk("tx_level", 32'(tx_level), 32'(m_tx.size()));
        chk("rx_level", 32'(rx_level), 32'(m_rx.size()));
        chk("tx_valid", 32'(midi_tx_valid), 32'(m_tx.size() > 0));
        chk("rvalid", 32'(cmd_rvalid), 32'(m_rx.size() > 0));
        if (m_tx.size() > 0) begin
            chk("tx_head", {8'd0, midi_tx_cmd, midi_tx_ch, 1'b0, midi_tx_data1, 1'b0, midi_tx_data2}, m_tx[0]);
        end
        if (m_rx.size() > 0) begin
            chk("rdata", cmd_rdata, m_rx[0]);
        end
        chk("drop_cnt", 32'(tx_drop_cnt), 32'(m_drop));
        chk("err_cnt", 32'(tx_err_cnt), 32'(m_err));
        chk("filt_cnt", 32'(rx_filt_cnt), 32'(m_filt));
    endtask

    // One cycle: check combinational outputs, advance model, clock, check state.
    task automatic tick();
        logic exp_rx_rd;
        #1;
        exp_rx_rd = midi_rx_valid && (m_rx.size() < RX_D);
        chk("rx_rd", 32'(midi_rx_rd), 32'(exp_rx_rd));
        chk("wbusy", 32'(cmd_wbusy), 32'((m_tx.size() >= AFULL) || midi_tx_busy));
        model_step(exp_rx_rd);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle_inputs();
        cmd_wr        = 1'b0;
        cmd_wdata     = '0;
        cmd_rd        = 1'b0;
        midi_tx_rd    = 1'b0;
        midi_tx_busy  = 1'b0;
        midi_rx_valid = 1'b0;
        midi_rx_cmd   = '0;
        midi_rx_ch    = '0;
        midi_rx_data1 = '0;
        midi_rx_data2 = '0;
        cnt_clr       = 1'b0;
    endtask

    task automatic drive_rx(input logic [31:0] w);
        midi_rx_valid = 1'b1;
        midi_rx_cmd   = w[23:20];
        midi_rx_ch    = w[19:16];
        midi_rx_data1 = w[14:8];
        midi_rx_data2 = w[6:0];
    endtask

    initial begin
        idle_inputs();
        rst     = 1'b1;
        ch_mask = 16'h0000;

        // Reset values.
        tick();
        tick();
        chk("rst_tx_valid", 32'(midi_tx_valid), 32'd0);
        chk("rst_rvalid", 32'(cmd_rvalid), 32'd0);
        chk("rst_tx_data", {8'd0, midi_tx_cmd, midi_tx_ch, 1'b0, midi_tx_data1, 1'b0, midi_tx_data2}, 32'd0);
        chk("rst_rdata", cmd_rdata, 32'd0);
        chk("rst_rx_rd", 32'(midi_rx_rd), 32'd0);
        chk("rst_wbusy", 32'(cmd_wbusy), 32'd0);
        rst = 1'b0;
        tick();

        // Single note-on through the TX path.
        cmd_wr    = 1'b1;
        cmd_wdata = 32'h0090_3C64;
        tick();
        cmd_wr = 1'b0;
        chk("tp1_valid", 32'(midi_tx_valid), 32'd1);
        chk("tp1_cmd", 32'(midi_tx_cmd), 32'h9);
        chk("tp1_ch", 32'(midi_tx_ch), 32'h0);
        chk("tp1_d1", 32'(midi_tx_data1), 32'h3C);
        chk("tp1_d2", 32'(midi_tx_data2), 32'h64);
        midi_tx_rd = 1'b1;
        tick();
        midi_tx_rd = 1'b0;
        chk("tp1_pop_valid", 32'(midi_tx_valid), 32'd0);
        chk("tp1_pop_level", 32'(tx_level), 32'd0);

        // Fill TX past full; almost-full at level 2, one drop.
        for (int i = 0; i < 5; i++) begin
            cmd_wr    = 1'b1;
            cmd_wdata = {8'hA5, 4'h9, 4'(i), 1'b1, 7'(i + 10), 1'b1, 7'(i)};
            tick();
            chk("afull_wbusy", 32'(cmd_wbusy), 32'((i + 1) >= AFULL));
        end
        cmd_wr = 1'b0;
        chk("fill_level", 32'(tx_level), 32'd4);
        chk("fill_drop", 32'(tx_drop_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_d2", 32'(midi_tx_data2), 32'(i));
            midi_tx_rd = 1'b1;
            tick();
        end
        midi_tx_rd = 1'b0;
        chk("drain_empty", 32'(midi_tx_valid), 32'd0);

        // Illegal command and transmitter-busy back-pressure.
        cmd_wr    = 1'b1;
        cmd_wdata = 32'h0050_0000;
        tick();
        cmd_wr = 1'b0;
        chk("err_cnt1", 32'(tx_err_cnt), 32'd1);
        chk("err_level", 32'(tx_level), 32'd0);
        midi_tx_busy = 1'b1;
        #1;
        chk("busy_only", 32'(cmd_wbusy), 32'd1);
        tick();
        midi_tx_busy = 1'b0;

        // Channel filter: ch1 accepted, ch2 filtered, system always accepted.
        ch_mask = 16'h0002;
        drive_rx(32'h0091_3C40);
        tick();
        drive_rx(32'h0092_3E40);
        tick();
        drive_rx(32'h00F8_0000);
        tick();
        midi_rx_valid = 1'b0;
        chk("filt_level", 32'(rx_level), 32'd2);
        chk("filt_cnt1", 32'(rx_filt_cnt), 32'd1);
        chk("rdata_ch1", 32'(cmd_rdata[31:16]), 32'h0091);
        cmd_rd = 1'b1;
        tick();
        chk("rdata_sys", 32'(cmd_rdata[31:16]), 32'h00F8);
        tick();
        cmd_rd = 1'b0;
        chk("rx_drained", 32'(cmd_rvalid), 32'd0);

        // RX back-pressure, single pop, then reset flush.
        ch_mask = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            drive_rx({8'd0, 4'h9, 4'(i), 1'b0, 7'(i + 40), 1'b0, 7'(i + 1)});
            tick();
        end
        chk("rxfull_rd", 32'(midi_rx_rd), 32'd0);
        chk("rxfull_level", 32'(rx_level), 32'd4);
        tick();
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        chk("rxpop_rd", 32'(midi_rx_rd), 32'd1);
        tick();
        chk("rxrefill_rd", 32'(midi_rx_rd), 32'd0);
        cmd_wr    = 1'b1;
        cmd_wdata = 32'h0080_0101;
        tick();
        cmd_wr = 1'b0;
        rst    = 1'b1;
        tick();
        rst           = 1'b0;
        midi_rx_valid = 1'b0;
        chk("flush_tx_level", 32'(tx_level), 32'd0);
        chk("flush_rx_level", 32'(rx_level), 32'd0);
        chk("flush_tx_valid", 32'(midi_tx_valid), 32'd0);
        chk("flush_rvalid", 32'(cmd_rvalid), 32'd0);

        // Counter saturation and clear-over-increment.
        for (int i = 0; i < 9; i++) begin
            cmd_wr    = 1'b1;
            cmd_wdata = {8'd0, 4'hB, 4'h3, 1'b0, 7'(i), 1'b0, 7'(i)};
            tick();
        end
        chk("sat_drop", 32'(tx_drop_cnt), 32'd3);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        cmd_wr  = 1'b0;
        chk("clr_drop", 32'(tx_drop_cnt), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            cmd_wr        = ($urandom_range(0, 1) == 1);
            cmd_wdata     = $urandom;
            midi_tx_rd    = ($urandom_range(0, 2) == 0);
            midi_tx_busy  = ($urandom_range(0, 3) == 0);
            midi_rx_valid = ($urandom_range(0, 1) == 1);
            midi_rx_cmd   = 4'($urandom);
            midi_rx_ch    = 4'($urandom);
            midi_rx_data1 = 7'($urandom);
            midi_rx_data2 = 7'($urandom);
            cmd_rd        = ($urandom_range(0, 2) == 0);
            cnt_clr       = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 31) == 0) ch_mask = 16'($urandom);
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
